// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: credit-limited imem requests, an in-order response queue and redirect flush.
// Define FETCH_PERF_CNT_EN to add the flush/empty performance counters.
module fetch_prefetch_queue #(
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DEPTH         = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
   input  logic                     imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
   input  logic                     pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   input  logic                     stall_d,
   output logic                     fd_valid,
   output logic [DATA_WIDTH-1:0]    fd_instr,
   output logic [ADDRESS_WIDTH-1:0] fd_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [ADDRESS_WIDTH-1:0] fd_pc_plus4,
   output logic [31:0]              perf_flush_cnt,
   output logic [31:0]              perf_empty_cnt
`else
   output logic [ADDRESS_WIDTH-1:0] fd_pc_plus4
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

   logic [ADDRESS_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]            count;
   logic [CW-1:0]            outstanding;
   logic [CW-1:0]            discard;
   logic [PW-1:0]            q_wr, q_rd;
   logic [PW-1:0]            tag_wr, tag_rd;

   logic [ADDRESS_WIDTH-1:0] q_pc    [DEPTH];
   logic [ADDRESS_WIDTH-1:0] q_pc4   [DEPTH];
   logic [DATA_WIDTH-1:0]    q_instr [DEPTH];
   logic [ADDRESS_WIDTH-1:0] tag_q   [DEPTH];

   logic credit_ok;
   logic req_fire;
   logic push;
   logic pop;

   // Queued entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
   assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
   // Gating with rst keeps the request channel quiet while reset is held.
   assign imem_req_valid = rst && credit_ok && !pc_src_e;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign push           = imem_rsp_valid && !pc_src_e && (discard == '0);
   assign fd_valid       = (count != '0);
   assign pop            = fd_valid && !stall_d && !pc_src_e;

   assign fd_instr    = fd_valid ? q_instr[q_rd] : NOP;
   assign fd_pc       = fd_valid ? q_pc[q_rd]    : '0;
   assign fd_pc_plus4 = fd_valid ? q_pc4[q_rd]   : '0;

   // NOTE: the storage arrays carry no reset; count/outstanding decide which slots are live.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         tag_q[tag_wr] <= fetch_pc;
      end
      if (push) begin
         q_pc[q_wr]    <= tag_q[tag_rd];
         q_pc4[q_wr]   <= tag_q[tag_rd] + ADDRESS_WIDTH'(4);
         q_instr[q_wr] <= imem_rsp_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         q_wr        <= '0;
         q_rd        <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         // The tag FIFO tracks every in-flight request, including ones that will be discarded.
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         tag_wr      <= tag_wr + PW'(req_fire);
         tag_rd      <= tag_rd + PW'(imem_rsp_valid);

         if (pc_src_e) begin
            fetch_pc <= pc_target_e;
            count    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            discard  <= outstanding - CW'(imem_rsp_valid);
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
            end
            if (imem_rsp_valid && (discard != '0)) begin
               discard <= discard - CW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            q_wr  <= q_wr + PW'(push);
            q_rd  <= q_rd + PW'(pop);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_flush_cnt <= '0;
         perf_empty_cnt <= '0;
      end else begin
         if (pc_src_e && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
         if (!fd_valid && (perf_empty_cnt != 32'hFFFF_FFFF)) begin
            perf_empty_cnt <= perf_empty_cnt + 32'd1;
         end
      end
   end
`else
`endif

endmodule
